// File: rtl/moving_average2_pkg.sv
// Shared types and defaults for the moving-average smoothing stage.
package moving_average2_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_LOG2_WINDOW = 2;
  localparam int DEFAULT_ACC_WIDTH   = DEFAULT_DATA_WIDTH + DEFAULT_LOG2_WINDOW;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;
  typedef logic signed [DEFAULT_ACC_WIDTH-1:0]  acc_t;

  // Widen a sample to accumulator width, preserving its sign.
  function automatic acc_t sext_sample(input sample_t s);
    return {{DEFAULT_LOG2_WINDOW{s[DEFAULT_DATA_WIDTH-1]}}, s};
  endfunction

endpackage

// File: rtl/moving_average2_if.sv
// Sample stream into the filter and smoothed stream out. There is no
// handshake: the filter takes eta_i1 on every rising clock edge and
// topLet_o is always valid one edge later. acc_dbg exposes the running
// sum so a checker can compare it with the window contents.
interface moving_average2_if
  import moving_average2_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
);
  logic signed [DATA_WIDTH-1:0] eta_i1;
  logic signed [DATA_WIDTH-1:0] topLet_o;
  logic signed [ACC_WIDTH-1:0]  acc_dbg;

  // Sample source / result consumer.
  modport master (
    output eta_i1,
    input  topLet_o,
    input  acc_dbg
  );

  // The filter itself.
  modport slave (
    input  eta_i1,
    output topLet_o,
    output acc_dbg
  );
endinterface

// File: rtl/moving_average2_delay_line.sv
// DEPTH-deep shift register with synchronous clear; exposes the oldest entry.
module moving_average2_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] oldest
);

  logic [WIDTH-1:0] taps [DEPTH];

  // Shift a new sample in at tap 0 each edge; clear wins over the shift.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign oldest = taps[DEPTH-1];

endmodule

// File: rtl/moving_average2_top_entity.sv
// Streaming moving-average filter: registered floor-mean of the last
// 2**LOG2_WINDOW signed samples, one sample per clock.
module moving_average2_top_entity
  import moving_average2_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int LOG2_WINDOW = DEFAULT_LOG2_WINDOW
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  moving_average2_if.slave  bus
);

  localparam int WINDOW = 2 ** LOG2_WINDOW;
  localparam int ACC_W  = DATA_WIDTH + LOG2_WINDOW;

  logic [DATA_WIDTH-1:0]   oldest;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] old_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_next;
  logic [DATA_WIDTH-1:0]   out_q;

  moving_average2_delay_line #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (WINDOW)
  ) u_delay_line (
    .clk    (system1000),
    .clr    (system1000_rst),
    .din    (bus.eta_i1),
    .oldest (oldest)
  );

  // Running sum: add the incoming sample, drop the one leaving the window.
  // The accumulator is wide enough for WINDOW extreme samples, so the true
  // sum never wraps.
  always_comb begin
    x_ext    = {{LOG2_WINDOW{bus.eta_i1[DATA_WIDTH-1]}}, bus.eta_i1};
    old_ext  = {{LOG2_WINDOW{oldest[DATA_WIDTH-1]}}, oldest};
    acc_next = acc_q + x_ext - old_ext;
  end

  // Register the sum and the mean. Taking the upper DATA_WIDTH bits of the
  // sum is the arithmetic right shift by LOG2_WINDOW (floor toward minus
  // infinity) already truncated to sample width; the mean always fits.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_next;
      out_q <= acc_next[ACC_W-1:LOG2_WINDOW];
    end
  end

  assign bus.topLet_o = out_q;
  assign bus.acc_dbg  = acc_q;

endmodule

// File: tb/tb_moving_average2_top_entity.sv
// Bench for the moving-average filter: directed plan followed by random
// samples with occasional resets, checked against a window-history model.
module tb_moving_average2_top_entity;
  import moving_average2_pkg::*;

  localparam int WIN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   hist [WIN];

  moving_average2_if bus ();

  moving_average2_top_entity dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .bus            (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Mean rounded toward minus infinity, from plain integer arithmetic.
  function automatic int floor_div(input int num, input int den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  // Apply one sample (or a reset) for one edge, then check the model.
  task automatic step(input int x, input bit do_rst);
    int      sum;
    int      mean;
    sample_t exp_out;
    acc_t    exp_acc;
    bus.eta_i1 = x[7:0];
    rst = do_rst;
    @(posedge clk);
    #1;
    if (do_rst) begin
      for (int i = 0; i < WIN; i++) hist[i] = 0;
    end else begin
      for (int i = WIN - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = x;
    end
    sum = 0;
    for (int i = 0; i < WIN; i++) sum += hist[i];
    mean    = floor_div(sum, WIN);
    exp_out = mean[7:0];
    exp_acc = sum[9:0];
    vectors++;
    assert (bus.topLet_o === exp_out)
      else begin
        miscompares++;
        $error("FAIL out x=%0d: got %0d expected %0d", x, bus.topLet_o, exp_out);
      end
    vectors++;
    assert (bus.acc_dbg === exp_acc)
      else begin
        miscompares++;
        $error("FAIL acc x=%0d: got %0d expected %0d", x, bus.acc_dbg, exp_acc);
      end
  endtask

  initial begin
    int r;
    for (int i = 0; i < WIN; i++) hist[i] = 0;
    bus.eta_i1 = 8'sd55;

    // Reset held for three edges with a non-zero input present.
    for (int i = 0; i < 3; i++) step(55, 1'b1);

    // Positive step: 2, 4, 6, 8, 8, 8.
    for (int i = 0; i < 6; i++) step(8, 1'b0);

    // Negative step from clean history: -2, -3, -4, -5, -5.
    step(0, 1'b1);
    for (int i = 0; i < 5; i++) step(-5, 1'b0);

    // Extremes: settle at 127, then slew to -128 with no wrap.
    for (int i = 0; i < 5; i++) step(127, 1'b0);
    for (int i = 0; i < 6; i++) step(-128, 1'b0);

    // Impulse: 25, 25, 25, 25, 0.
    step(0, 1'b1);
    step(100, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 1'b0);

    // Mid-stream reset clears all history.
    for (int i = 0; i < 4; i++) step(40, 1'b0);
    step(40, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 1'b0);

    // Random samples with occasional reset.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 255)) - 128;
      step(r, $urandom_range(0, 29) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
